// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall bus type,
// stall masks and FSM state encodings.
package pipeline_ctrl_pkg;

  localparam int STALL_W = 6;

  typedef logic [STALL_W-1:0] stall_bus_t;

  // Masks are monotone: a held stage always holds every stage upstream of it.
  localparam stall_bus_t STALL_MEM  = 6'b011111;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_IF   = 6'b000011;
  localparam stall_bus_t STALL_NONE = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FLUSH_PEND = 2'd1,
    ST_DISCARD    = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_stall_encoder.sv
// Priority encoder mapping stall requests and controller busy status onto the
// per-stage hold bus.
module stall_encoder
  import pipeline_ctrl_pkg::*;
(
  input  logic       if_stall_req,
  input  logic       id_stall_req,
  input  logic       mem_stall_req,
  input  logic       busy,
  output stall_bus_t stall_sign
);

  always_comb begin
    stall_sign = STALL_NONE;
    if (mem_stall_req) begin
      stall_sign = STALL_MEM;
    end else if (id_stall_req) begin
      stall_sign = STALL_ID;
    end else if (if_stall_req || busy) begin
      stall_sign = STALL_IF;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stall priority, branch-redirect flush sequencing
// and squashed-fetch discard. Optional perf counters under STALL_PERF_EN.
//
//   state         | meaning
//   ST_IDLE       | no redirect in progress
//   ST_FLUSH_PEND | branch seen while mem held ex; flush waits for mem release
//   ST_DISCARD    | fetch outstanding for squashed path; drop its response
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall_req,
  input  logic        id_stall_req,
  input  logic        mem_stall_req,
  input  logic        ex_branch_taken,
  output logic [5:0]  stall_sign,
  output logic        flush,
  output logic        if_discard,
`ifdef STALL_PERF_EN
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count,
`endif
  output logic [1:0]  state
);

  state_t     state_q, state_d;
  logic       flush_d, discard_d, flush_q;
  stall_bus_t stall_enc;

  stall_encoder u_stall_encoder (
    .if_stall_req  (if_stall_req),
    .id_stall_req  (id_stall_req),
    .mem_stall_req (mem_stall_req),
    .busy          (state_q != ST_IDLE),
    .stall_sign    (stall_enc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush;
    end
  end

  always_comb begin
    state_d   = state_q;
    flush_d   = 1'b0;
    discard_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A branch right after a flush is the squashed instruction; ignore it.
        if (ex_branch_taken && !flush_q) begin
          if (mem_stall_req) begin
            state_d = ST_FLUSH_PEND;
          end else begin
            flush_d = 1'b1;
            if (if_stall_req) state_d = ST_DISCARD;
          end
        end
      end
      ST_FLUSH_PEND: begin
        if (!mem_stall_req) begin
          flush_d = 1'b1;
          state_d = if_stall_req ? ST_DISCARD : ST_IDLE;
        end
      end
      ST_DISCARD: begin
        discard_d = if_stall_req;
        if (!if_stall_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign flush      = flush_d & ~rst;
  assign if_discard = discard_d & ~rst;
  assign stall_sign = rst ? STALL_NONE : stall_enc;
  assign state      = state_q;

`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_sign != STALL_NONE) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush)                    perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; perf counter checks are
// compiled in only when STALL_PERF_EN is defined.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       if_stall_req = 1'b0;
  logic       id_stall_req = 1'b0;
  logic       mem_stall_req = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic [5:0] stall_sign;
  logic       flush;
  logic       if_discard;
  logic [1:0] state;
`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  int total = 0;
  int bad   = 0;

  pipeline_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .if_stall_req    (if_stall_req),
    .id_stall_req    (id_stall_req),
    .mem_stall_req   (mem_stall_req),
    .ex_branch_taken (ex_branch_taken),
    .stall_sign      (stall_sign),
    .flush           (flush),
    .if_discard      (if_discard),
`ifdef STALL_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count),
`endif
    .state           (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs change just after the rising edge, checks at the falling edge.
  task automatic go(input logic r, input logic i_f, input logic i_d,
                    input logic i_m, input logic br);
    @(posedge clk);
    #1;
    rst = r; if_stall_req = i_f; id_stall_req = i_d;
    mem_stall_req = i_m; ex_branch_taken = br;
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [5:0] st, input logic fl,
                         input logic dc, input logic [1:0] s);
    chk({tag, ".stall"},   32'(stall_sign), 32'(st));
    chk({tag, ".flush"},   32'(flush),      32'(fl));
    chk({tag, ".discard"}, 32'(if_discard), 32'(dc));
    chk({tag, ".state"},   32'(state),      32'(s));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // reset gates outputs whatever the inputs
    go(1, 1, 1, 1, 1); chk_out("rst_gate", 6'b000000, 0, 0, 2'd0);
    go(1, 0, 0, 0, 0); chk_out("rst_idle", 6'b000000, 0, 0, 2'd0);

    for (int i = 0; i < 10; i++) begin
      go(0, 0, 0, 0, 0); chk_out("quiet", 6'b000000, 0, 0, 2'd0);
    end

    go(0, 0, 1, 0, 0); chk_out("id_stall", 6'b000111, 0, 0, 2'd0);
    go(0, 0, 0, 0, 0); chk_out("id_after", 6'b000000, 0, 0, 2'd0);
    go(0, 1, 0, 0, 0); chk_out("if_stall", 6'b000011, 0, 0, 2'd0);
    go(0, 1, 1, 1, 0); chk_out("prio_all", 6'b011111, 0, 0, 2'd0);
    go(0, 1, 1, 0, 0); chk_out("prio_id",  6'b000111, 0, 0, 2'd0);

    // branch under mem stall defers flush
    go(0, 0, 0, 1, 0); chk_out("fp_c0", 6'b011111, 0, 0, 2'd0);
    go(0, 0, 0, 1, 1); chk_out("fp_c1", 6'b011111, 0, 0, 2'd0);
    go(0, 0, 0, 1, 0); chk_out("fp_c2", 6'b011111, 0, 0, 2'd1);
    go(0, 0, 0, 1, 0); chk_out("fp_c3", 6'b011111, 0, 0, 2'd1);
    go(0, 0, 0, 0, 0); chk_out("fp_c4", 6'b000011, 1, 0, 2'd1);
    go(0, 0, 0, 0, 0); chk_out("fp_c5", 6'b000000, 0, 0, 2'd0);

    // branch with fetch outstanding -> discard
    go(0, 1, 0, 0, 1); chk_out("dc_c0", 6'b000011, 1, 0, 2'd0);
    go(0, 1, 0, 0, 0); chk_out("dc_c1", 6'b000011, 0, 1, 2'd2);
    go(0, 1, 0, 0, 0); chk_out("dc_c2", 6'b000011, 0, 1, 2'd2);
    go(0, 1, 0, 0, 0); chk_out("dc_c3", 6'b000011, 0, 1, 2'd2);
    go(0, 0, 0, 0, 0); chk_out("dc_c4", 6'b000011, 0, 0, 2'd2);
    go(0, 0, 0, 0, 0); chk_out("dc_c5", 6'b000000, 0, 0, 2'd0);

    // flush wins over load-use
    go(0, 0, 1, 0, 1); chk_out("id_br", 6'b000111, 1, 0, 2'd0);
    go(0, 0, 0, 0, 0); chk_out("id_br1", 6'b000000, 0, 0, 2'd0);

    // back-to-back branch is absorbed
    go(0, 0, 0, 0, 1); chk_out("b2b_0", 6'b000000, 1, 0, 2'd0);
    go(0, 0, 0, 0, 1); chk_out("b2b_1", 6'b000000, 0, 0, 2'd0);
    go(0, 0, 0, 0, 0); chk_out("b2b_2", 6'b000000, 0, 0, 2'd0);

    // second branch in FLUSH_PEND absorbed
    go(0, 0, 0, 1, 1); chk_out("fpa_0", 6'b011111, 0, 0, 2'd0);
    go(0, 0, 0, 1, 1); chk_out("fpa_1", 6'b011111, 0, 0, 2'd1);
    go(0, 0, 0, 0, 0); chk_out("fpa_2", 6'b000011, 1, 0, 2'd1);
    go(0, 0, 0, 0, 0); chk_out("fpa_3", 6'b000000, 0, 0, 2'd0);

    // second branch in DISCARD absorbed
    go(0, 1, 0, 0, 1); chk_out("dca_0", 6'b000011, 1, 0, 2'd0);
    go(0, 1, 0, 0, 1); chk_out("dca_1", 6'b000011, 0, 1, 2'd2);
    go(0, 0, 0, 0, 0); chk_out("dca_2", 6'b000011, 0, 0, 2'd2);
    go(0, 0, 0, 0, 0); chk_out("dca_3", 6'b000000, 0, 0, 2'd0);

    // FLUSH_PEND releasing into DISCARD
    go(0, 0, 0, 1, 1); chk_out("fpd_0", 6'b011111, 0, 0, 2'd0);
    go(0, 1, 0, 0, 0); chk_out("fpd_1", 6'b000011, 1, 0, 2'd1);
    go(0, 1, 0, 0, 0); chk_out("fpd_2", 6'b000011, 0, 1, 2'd2);
    go(0, 0, 0, 0, 0); chk_out("fpd_3", 6'b000011, 0, 0, 2'd2);
    go(0, 0, 0, 0, 0); chk_out("fpd_4", 6'b000000, 0, 0, 2'd0);

    // reset mid-FLUSH_PEND drops the pending flush
    go(0, 0, 0, 1, 1); chk_out("rfp_0", 6'b011111, 0, 0, 2'd0);
    go(0, 0, 0, 1, 0); chk_out("rfp_1", 6'b011111, 0, 0, 2'd1);
    go(1, 0, 0, 0, 0); chk_out("rfp_2", 6'b000000, 0, 0, 2'd1);
    go(0, 0, 0, 0, 0); chk_out("rfp_3", 6'b000000, 0, 0, 2'd0);
    go(0, 0, 0, 0, 0); chk_out("rfp_4", 6'b000000, 0, 0, 2'd0);

    // reset mid-DISCARD
    go(0, 1, 0, 0, 1); chk_out("rdc_0", 6'b000011, 1, 0, 2'd0);
    go(1, 1, 0, 0, 0); chk_out("rdc_1", 6'b000000, 0, 0, 2'd2);
    go(0, 1, 0, 0, 0); chk_out("rdc_2", 6'b000011, 0, 0, 2'd0);
    go(0, 0, 0, 0, 0); chk_out("rdc_3", 6'b000000, 0, 0, 2'd0);

`ifdef STALL_PERF_EN
    go(1, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0);
    chk("perf_rst_stall", perf_stall_cycles, 32'd0);
    chk("perf_rst_flush", perf_flush_count, 32'd0);
    for (int i = 0; i < 5; i++) go(0, 0, 1, 0, 0);
    go(0, 0, 0, 0, 1);
    go(0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 1);
    go(0, 0, 0, 0, 0);
    chk("perf_stall5", perf_stall_cycles, 32'd5);
    chk("perf_flush2", perf_flush_count, 32'd2);
    dut.perf_stall_q = 32'hFFFF_FFFF;
    go(0, 0, 1, 0, 0);
    chk("perf_preload", perf_stall_cycles, 32'hFFFF_FFFF);
    go(0, 0, 0, 0, 0);
    chk("perf_wrap", perf_stall_cycles, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first: clk, in, 1, clock; rst, in, 1, reset, synchronous, active-high.
REQ-002 if_stall_req, in, 1: instruction fetch outstanding at the memory port.
REQ-003 id_stall_req, in, 1: load-use hazard detected in decode.
REQ-004 mem_stall_req, in, 1: data access outstanding at the memory port.
REQ-005 ex_branch_taken, in, 1: single-cycle pulse from ex, redirect resolved.
REQ-006 stall_sign, out, 6: per-stage hold; bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
REQ-007 flush, out, 1: the if/id and id/ex registers load a bubble this cycle.
REQ-008 if_discard, out, 1: the fetch response currently in flight is for a squashed path and is dropped.
REQ-009 state, out, 2: current FSM state, for debug.

Function
REQ-010 stall_sign SHALL be combinational from the inputs and the current state, with this priority: mem_stall_req -> 6'b011111; else id_stall_req -> 6'b000111; else if_stall_req or state!=IDLE -> 6'b000011; else 6'b000000.
REQ-011 stall_sign SHALL be monotone: if bit i is set, every bit below i is also set; bit5 is never set.
REQ-012 The FSM SHALL have three states: IDLE=0, FLUSH_PEND=1, DISCARD=2.
REQ-013 IDLE, ex_branch_taken with mem_stall_req=1: go to FLUSH_PEND; flush=0 (ex is held, so the redirect is deferred).
REQ-014 IDLE, ex_branch_taken with mem_stall_req=0: flush=1 in the same cycle; go to DISCARD if if_stall_req=1, else stay in IDLE.
REQ-015 FLUSH_PEND: flush=1 in the first cycle mem_stall_req=0; then go to DISCARD if if_stall_req=1, else to IDLE.
REQ-016 DISCARD: if_discard=1 while if_stall_req=1; go to IDLE in the cycle after if_stall_req falls; stall_sign[1:0] stays held throughout.
REQ-017 A second ex_branch_taken in FLUSH_PEND or DISCARD SHALL be absorbed, with no extra flush pulse; the ex stage does not issue a new branch while it is held or flushed.
REQ-018 flush SHALL never be high for two consecutive cycles.
REQ-019 When id_stall_req and ex_branch_taken are both asserted in a cycle that issues flush, flush wins: the load-use instruction is squashed and stall_sign follows REQ-010 unchanged.

Reset
REQ-020 When rst=1 at a clk edge, state SHALL become IDLE and the perf counters SHALL become 0.
REQ-021 During reset, flush=0, if_discard=0 and stall_sign=6'b000000, regardless of the inputs.
REQ-022 A reset mid-FLUSH_PEND or mid-DISCARD SHALL drop the pending action with no flush pulse afterward.

Configuration
REQ-023 With STALL_PERF_EN defined, the block SHALL add outputs perf_stall_cycles (32) and perf_flush_count (32).
REQ-024 perf_stall_cycles SHALL increment each cycle stall_sign!=0; perf_flush_count SHALL increment each cycle flush=1; both wrap at 2^32-1 to 0.
REQ-025 Without STALL_PERF_EN, the counters and their ports SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 The shared defines package SHALL hold `StallBus (5:0), the stall masks STALL_MEM, STALL_ID, STALL_IF and STALL_NONE, and the FSM state encodings.
REQ-027 The stall-priority encoder SHALL be one combinational sub-module, stall_encoder; the FSM and counters SHALL live in pipeline_ctrl.

Verification
REQ-028 With all requests low and no branch, stall_sign SHALL be 6'b000000, flush=0 and state=0 for 10 cycles.
REQ-029 With id_stall_req=1 for 1 cycle, stall_sign SHALL be 6'b000111 that cycle and 6'b000000 the next.
REQ-030 With mem_stall_req=1 for cycles 0-3 and ex_branch_taken pulsed in cycle 1: stall_sign=6'b011111 in cycles 0-3; state=1 in cycles 2-3; flush=1 only in cycle 4; then state=0.
REQ-031 With ex_branch_taken while if_stall_req=1 for 3 more cycles: flush=1 for 1 cycle; if_discard=1 for 3 cycles; state=2; then state=0 one cycle after if_stall_req falls.
REQ-032 With rst asserted in cycle 2 of a FLUSH_PEND episode: no flush occurs afterward, and state=0.
REQ-033 With STALL_PERF_EN defined and 5 stall cycles plus 2 branches applied, perf_stall_cycles SHALL be 5 and perf_flush_count SHALL be 2; preloading perf_stall_cycles to 32'hFFFFFFFF then applying 1 stall cycle SHALL give 0.
